// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback stage: load funct3 codes,
// FSM state type and default widths.
package wb_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_ADDR_WIDTH = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// Combinational load data selection: picks the byte/halfword addressed by the
// low address bits and sign- or zero-extends it to the register width.
module load_extract
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    output logic [DATA_WIDTH-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword selection ignores offset[0]; misaligned halves are not flagged.
    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        value = word;
        case (funct3)
            LB:      value = {{(DATA_WIDTH - 8){byte_sel[7]}}, byte_sel};
            LBU:     value = {{(DATA_WIDTH - 8){1'b0}}, byte_sel};
            LH:      value = {{(DATA_WIDTH - 16){half_sel[15]}}, half_sel};
            LHU:     value = {{(DATA_WIDTH - 16){1'b0}}, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage feeding the register file write port; merges ALU results and
// one outstanding load. Define WB_FWD_EN to add next-cycle write bypass outputs.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_offset,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]            ld_funct3_q, ld_funct3_d;
    logic [1:0]            ld_offset_q, ld_offset_d;
    logic                  wen_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] ld_value;

    load_extract #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extract (
        .word  (mem_rdata),
        .funct3(ld_funct3_q),
        .offset(ld_offset_q),
        .value (ld_value)
    );

    assign ld_ready   = (state_q == IDLE);
    assign mem_rready = (state_q == WAIT_MEM);
    assign busy       = (state_q == WAIT_MEM);

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_offset_d = ld_offset_q;
        wen_d       = 1'b0;
        waddr_d     = waddr;
        wdata_d     = wdata;
        unique case (state_q)
            IDLE: begin
                // An ALU write and a load accept in the same cycle both proceed.
                if (alu_valid) begin
                    wen_d   = (alu_rd != '0);
                    waddr_d = alu_rd;
                    wdata_d = alu_result;
                end
                if (ld_valid) begin
                    ld_rd_d     = ld_rd;
                    ld_funct3_d = ld_funct3;
                    ld_offset_d = ld_offset;
                    state_d     = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                // ALU results arriving while a load is outstanding are dropped.
                if (mem_rvalid) begin
                    wen_d   = (ld_rd_q != '0);
                    waddr_d = ld_rd_q;
                    wdata_d = ld_value;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ld_rd_q     <= '0;
            ld_funct3_q <= '0;
            ld_offset_q <= '0;
            wen         <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_funct3_q <= ld_funct3_d;
            ld_offset_q <= ld_offset_d;
            wen         <= wen_d;
            waddr       <= waddr_d;
            wdata       <= wdata_d;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = wen_d && rst;
    assign fwd_rd    = waddr_d;
    assign fwd_data  = wdata_d;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized scoreboard bench for reg_writeback: a stimulus process predicts
// register-file writes, a negedge monitor checks them cycle by cycle.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_result = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_offset = '0;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    reg_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_result(alu_result),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_funct3 (ld_funct3),
        .ld_offset (ld_offset),
        .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata)
`ifdef WB_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;

    // Reference model state: one outstanding load or none.
    bit          m_busy = 1'b0;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] ref_ld(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("wen_write", {31'b0, wen}, {31'b0, e.rd != 5'd0});
                exp_addr = e.rd;
                exp_data = e.data;
            end else begin
                chk("wen_idle", {31'b0, wen}, 32'd0);
            end
            chk("waddr", {27'b0, waddr}, {27'b0, exp_addr});
            chk("wdata", wdata, exp_data);
        end
    end

    // One cycle of stimulus; the model predicts the resulting write.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] off, input logic rv, input logic [31:0] rdata);
        bit          sched;
        logic [4:0]  s_rd;
        logic [31:0] s_data;
        @(posedge clk);
        #1;
        alu_valid = av; alu_rd = ard; alu_result = ares;
        ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_offset = off;
        mem_rvalid = rv; mem_rdata = rdata;
        #1;
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, !m_busy});
        chk("mem_rready", {31'b0, mem_rready}, {31'b0, m_busy});
        sched = 1'b0;
        s_rd = '0;
        s_data = '0;
        if (!m_busy) begin
            if (av) begin
                sched = 1'b1; s_rd = ard; s_data = ares;
            end
            if (lv) begin
                m_busy = 1'b1; m_rd = lrd; m_f3 = f3; m_off = off;
            end
        end else if (rv) begin
            sched = 1'b1; s_rd = m_rd; s_data = ref_ld(rdata, m_f3, m_off);
            m_busy = 1'b0;
        end
        if (sched) sb.push_back('{due: cyc + 1, rd: s_rd, data: s_data});
`ifdef WB_FWD_EN
        chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, sched && s_rd != 5'd0});
        if (sched) begin
            chk("fwd_rd", {27'b0, fwd_rd}, {27'b0, s_rd});
            chk("fwd_data", fwd_data, s_data);
        end
`endif
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        alu_valid = 1'b0; ld_valid = 1'b0; mem_rvalid = 1'b0;
        sb.delete();
        exp_addr = '0;
        exp_data = '0;
        m_busy = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("rst_wen", {31'b0, wen}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] data);
        step(1'b0, 5'd0, 32'd0, 1'b1, rd, f3, off, 1'b0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, data);
    endtask

    initial begin
        #12;
        chk("reset_wen", {31'b0, wen}, 32'd0);
        chk("reset_waddr", {27'b0, waddr}, 32'd0);
        chk("reset_wdata", wdata, 32'd0);
        chk("reset_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("reset_mem_rready", {31'b0, mem_rready}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        idle();
        load(5'd1, 3'b000, 2'd3, 32'h80FF_0000);
        load(5'd2, 3'b100, 2'd3, 32'h80FF_0000);
        load(5'd3, 3'b001, 2'd2, 32'h80FF_0000);
        load(5'd4, 3'b101, 2'd2, 32'h80FF_0000);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'b010, 2'd1, 1'b0, 32'd0);
        repeat (4) step(1'b1, 5'd9, 32'hAAAA_5555, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        load(5'd0, 3'b010, 2'd0, 32'h0BAD_F00D);
        idle();
        step(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd12, 3'b010, 2'd0, 1'b0, 32'd0);
        idle();
        do_reset();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h5555_AAAA);
        idle();

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, 5'($urandom), $urandom,
                 $urandom_range(0, 2) == 0, 5'($urandom), 3'($urandom), 2'($urandom),
                 $urandom_range(0, 3) == 0, $urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        idle();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes never observed, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage directly upstream of the CPU register file. It merges single-cycle ALU results and multi-cycle load responses into the register file's single write port (wen/waddr/wdata). It also performs load byte/halfword selection with sign or zero extension, and suppresses writes to x0. A two-state FSM tracks at most one outstanding load and back-pressures upstream while that load waits for memory.

## Interface
Parameters:
- DATA_WIDTH, 32, register/data width
- ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_result  in  DATA_WIDTH  ALU result
- ld_valid  in  1  load issue request
- ld_ready  out  1  load request accepted when high with ld_valid
- ld_rd  in  ADDR_WIDTH  load destination register
- ld_funct3  in  3  RISC-V load funct3
- ld_offset  in  2  byte address bits [1:0]
- mem_rvalid  in  1  memory read data valid
- mem_rready  out  1  stage ready for read data
- mem_rdata  in  DATA_WIDTH  raw aligned memory word
- busy  out  1  load outstanding; upstream stalls
- wen  out  1  register file write enable (registered)
- waddr  out  ADDR_WIDTH  register file write address (registered)
- wdata  out  DATA_WIDTH  register file write data (registered)

## Operation
- FSM states: IDLE, WAIT_MEM. Reset state is IDLE.
- IDLE:
  - ld_ready=1, mem_rready=0, busy=0.
  - ld_valid&ld_ready: latch ld_rd/ld_funct3/ld_offset, go to WAIT_MEM.
- WAIT_MEM:
  - ld_ready=0, mem_rready=1, busy=1.
  - mem_rvalid: extract, schedule write, go to IDLE.
- ALU path: alu_valid in IDLE schedules write {alu_rd, alu_result}.
  - alu_valid in WAIT_MEM is a protocol violation and is ignored (no write).
- Simultaneous alu_valid and load accept in IDLE: both take effect. The ALU write issues, and the load goes to WAIT_MEM.
- Extraction (funct3):
  - 000 LB: byte ld_offset, sign-extend.
  - 100 LBU: byte ld_offset, zero-extend.
  - 001 LH: half ld_offset[1], sign-extend.
  - 101 LHU: half ld_offset[1], zero-extend.
  - 010 LW: full word, offset ignored.
  - 011/110/111: treated as LW.
- Half loads ignore ld_offset[0]; misalignment is not flagged.
- x0: any scheduled write with rd==0 produces wen=0. waddr/wdata still update.
- wen is a one-cycle pulse per write. With no write scheduled, wen=0 and waddr/wdata hold.

## Timing
- Reset (rst low, async):
  - state=IDLE, wen=0, waddr=0, wdata=0, latched load fields=0.
  - ld_ready=1, mem_rready=0, busy=0.
- ld_ready, mem_rready, busy: combinational from state only.
- ALU latency: wen high on the cycle after alu_valid.
- Load latency: accept at cycle N → WAIT_MEM at N+1.
  - mem_rvalid at cycle M≥N+1 → wen at M+1, IDLE at M+1.
  - A new load can be accepted at M+1, giving back-to-back loads every 2 cycles minimum.
- mem_rvalid in IDLE is ignored (mem_rready=0).
- Reset asserted mid-load: outstanding load dropped, no write issued. A late mem_rvalid after reset is ignored.

## Configuration
- WB_FWD_EN defined: adds outputs fwd_valid(1), fwd_rd(ADDR_WIDTH), fwd_data(DATA_WIDTH).
  - These are combinational copies of the next-cycle write (next-state of wen/waddr/wdata), for same-cycle bypass into decode.
  - fwd_valid=0 when rd==0 and during reset.
- Not defined: the ports are absent; no forwarding logic.

## Structure
- Package wb_pkg holds:
  - the funct3 load constants (LB, LH, LW, LBU, LHU);
  - the state enum (IDLE, WAIT_MEM);
  - the DATA_WIDTH/ADDR_WIDTH defaults.
- One sub-module, load_extract: combinational word + funct3 + offset → extended value.

## Test plan
- Reset, then alu_valid, alu_rd=5, alu_result=0x1234_5678 → next cycle wen=1, waddr=5, wdata=0x1234_5678; cycle after, wen=0.
- LB, offset=3, mem_rdata=0x80FF_0000 → wdata=0xFFFF_FF80. LBU same → 0x0000_0080. LH offset=2 → 0xFFFF_80FF. LHU → 0x0000_80FF.
- Load accepted, mem_rvalid held low for 4 cycles: busy=1, ld_ready=0, no wen. mem_rvalid with 0xDEAD_BEEF, LW, rd=7 → wen=1, waddr=7, wdata=0xDEAD_BEEF the next cycle.
- alu_rd=0 and load rd=0 → wen stays 0 throughout.
- Simultaneous alu_valid (rd=3) and load accept → wen for rd=3 next cycle, FSM in WAIT_MEM. rst pulsed low during WAIT_MEM → state IDLE, subsequent mem_rvalid produces no write.
- With WB_FWD_EN: fwd_valid/fwd_rd/fwd_data equal the values of wen/waddr/wdata one cycle later, for every case above.
